// File: rtl/ahb3lite_sram_ws.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_ws
//
// AHB3-Lite SRAM slave with a configurable number of wait states, byte-lane
// writes, a two-cycle ERROR response for illegal transfers, and write-to-read
// forwarding. The memory is MEM_SIZE bytes, organised as words of HDATA_SIZE
// bits.
//
// Ports
//   HCLK       bus clock, rising edge
//   HRESETn    asynchronous active-low reset
//   HSEL       slave select
//   HADDR      byte address
//   HWDATA     write data, little-endian byte lanes
//   HWRITE     1 = write
//   HSIZE      log2 of transfer size in bytes
//   HBURST     burst type (no functional effect)
//   HPROT      protection (no functional effect)
//   HTRANS     IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   HREADY     bus-level ready
//   HREADYOUT  slave ready
//   HRESP      0 = OKAY, 1 = ERROR
//   HRDATA     read data
//
// State  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no data phase in progress; ready, OKAY
// S_WAIT | legal data phase stalled; counter runs down to zero
// S_DONE | legal data phase completes; read data shown, write commits
// S_ERR1 | first ERROR cycle; HREADYOUT low
// S_ERR2 | second ERROR cycle; HREADYOUT high
// ---------------------------------------------------------------------------
module ahb3lite_sram_ws #(
  parameter int MEM_SIZE    = 256,
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [HDATA_SIZE-1:0] HRDATA
);

  localparam int BYTES = HDATA_SIZE / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int DEPTH = MEM_SIZE / BYTES;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter preload; only meaningful when wait states are configured.
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DONE = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BYTES-1:0]      mask_q, mask_d;
  logic                  write_q, write_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;
  logic [HDATA_SIZE-1:0] hrdata_q, hrdata_d;

  logic [HDATA_SIZE-1:0] mem_q [DEPTH];

  logic                  accept;
  logic                  illegal;
  logic [HADDR_SIZE-1:0] align_mask;
  logic [BYTES-1:0]      mask_in;
  logic [IW-1:0]         idx_in;
  logic                  mem_we;
  logic [IW-1:0]         rd_idx;
  logic                  rd_is_read;
  logic [HDATA_SIZE-1:0] rd_word;

  // HBURST/HPROT carry no function here; HTRANS[0] only distinguishes SEQ.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

  // ------------------------------------------------------------------
  // Address-phase decode
  // ------------------------------------------------------------------
  always_comb begin
    accept     = HSEL & HREADY & HTRANS[1];
    idx_in     = HADDR[LB +: IW];
    align_mask = (HADDR_SIZE'(1) << HSIZE) - HADDR_SIZE'(1);
    illegal    = (HADDR >= HADDR_SIZE'(MEM_SIZE)) ||
                 (HSIZE > 3'(LB)) ||
                 ((HADDR & align_mask) != '0);
    // Lanes [offset, offset + 2^HSIZE). For legal transfers this never
    // runs past the top lane; illegal transfers never use the mask.
    mask_in = '0;
    for (int i = 0; i < BYTES; i++) begin
      if ((i >= int'(HADDR[LB-1:0])) &&
          (i < int'(HADDR[LB-1:0]) + (1 << HSIZE))) begin
        mask_in[i] = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Read path with forwarding
  // ------------------------------------------------------------------
  // A write commits on the edge that ends S_DONE. A read chained straight
  // behind it samples the memory on that same edge, so the write's masked
  // lanes are merged in here rather than returning the stale word.
  always_comb begin
    mem_we     = (state_q == S_DONE) && write_q;
    rd_idx     = (state_q == S_WAIT) ? idx_q : idx_in;
    rd_is_read = (state_q == S_WAIT) ? !write_q : !HWRITE;
    rd_word    = mem_q[rd_idx];
    if (mem_we && (idx_q == rd_idx)) begin
      for (int i = 0; i < BYTES; i++) begin
        if (mask_q[i]) begin
          rd_word[8*i +: 8] = HWDATA[8*i +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    write_d = write_q;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        // S_IDLE, S_DONE and S_ERR2 drive HREADYOUT high, so a new address
        // phase may be taken here and chained without a bubble.
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = idx_in;
          mask_d  = mask_in;
          write_d = HWRITE;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
    endcase

    hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);

    hrdata_d = hrdata_q;
    if ((state_d == S_DONE) && rd_is_read) begin
      hrdata_d = rd_word;
    end
  end

  // ------------------------------------------------------------------
  // Control and output registers
  // ------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      idx_q       <= '0;
      mask_q      <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Storage is not reset. A write still pending when reset hits is lost
  // because state_q leaves S_DONE asynchronously.
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (mask_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
module tb_ahb3lite_sram_ws;

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        write;
    bit [31:0] addr;
    bit [2:0]  size;
    bit [31:0] wdata;
    bit        err;
    bit        chk_rd;
    bit [31:0] rdata;
  } vec_t;

  typedef struct {
    bit        err;
    bit        chk_rd;
    bit [31:0] rdata;
    int        low;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        hsel      [2];
  logic        hwrite    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] haddr     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [3:0]  hprot     [2];
  logic [1:0]  htrans    [2];

  always #5 clk = ~clk;

  // Instance 0: zero wait states. Instance 1: three wait states.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign hready[g] = hreadyout[g];
    ahb3lite_sram_ws #(
      .MEM_SIZE   (256),
      .HADDR_SIZE (32),
      .HDATA_SIZE (32),
      .WAIT_STATES(3 * g)
    ) u_dut (
      .HCLK     (clk),
      .HRESETn  (rst_n[g]),
      .HSEL     (hsel[g]),
      .HADDR    (haddr[g]),
      .HWDATA   (hwdata[g]),
      .HWRITE   (hwrite[g]),
      .HSIZE    (hsize[g]),
      .HBURST   (hburst[g]),
      .HPROT    (hprot[g]),
      .HTRANS   (htrans[g]),
      .HREADY   (hready[g]),
      .HREADYOUT(hreadyout[g]),
      .HRESP    (hresp[g]),
      .HRDATA   (hrdata[g])
    );
  end

  int   n_checks = 0;
  int   n_err    = 0;
  vec_t cur_q[$];
  exp_t exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit sel, bit [1:0] tr, bit wr, bit [31:0] a, bit [2:0] sz,
                              bit [31:0] wd, bit err, bit chk, bit [31:0] rd);
    vec_t v;
    v.sel = sel; v.trans = tr; v.write = wr; v.addr = a; v.size = sz;
    v.wdata = wd; v.err = err; v.chk_rd = chk; v.rdata = rd;
    return v;
  endfunction

  function automatic vec_t wr(bit [31:0] a, bit [2:0] sz, bit [31:0] d, bit err);
    return mk(1'b1, 2'd2, 1'b1, a, sz, d, err, 1'b0, 32'h0);
  endfunction

  function automatic vec_t rd(bit [31:0] a, bit [2:0] sz, bit [31:0] exp, bit err);
    return mk(1'b1, 2'd2, 1'b0, a, sz, 32'h0, err, !err, exp);
  endfunction

  task automatic drive_addr(input int d, input vec_t v);
    hsel[d]   = v.sel;
    htrans[d] = v.trans;
    hwrite[d] = v.write;
    haddr[d]  = v.addr;
    hsize[d]  = v.size;
    hburst[d] = 3'd0;
    hprot[d]  = 4'b0011;
  endtask

  task automatic drive_idle(input int d);
    hsel[d]   = 1'b0;
    htrans[d] = 2'd0;
    hwrite[d] = 1'b0;
    haddr[d]  = 32'h0;
    hsize[d]  = 3'd2;
  endtask

  // Present the next vector of cur_q (or IDLE) and push its expectation.
  task automatic present(input int d, input int ws, inout int idx, output vec_t v, output bit v_ok);
    exp_t e;
    if (idx < cur_q.size()) begin
      v = cur_q[idx];
      idx++;
      v_ok = 1'b1;
      drive_addr(d, v);
      e.err    = v.err;
      e.chk_rd = v.chk_rd;
      e.rdata  = v.rdata;
      e.low    = (v.sel && v.trans[1]) ? (v.err ? 1 : ws) : 0;
      exp_q.push_back(e);
    end else begin
      v    = mk(1'b0, 2'd0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0);
      v_ok = 1'b0;
      drive_idle(d);
    end
  endtask

  // Pipelined AHB master: called just after a rising edge with HREADYOUT high.
  task automatic run_seq(input int d, input int ws);
    vec_t pres, dph;
    bit   pres_v, dph_v, ready_prev, lowresp_bad;
    int   idx, low, budget;
    exp_t e;
    idx = 0; dph_v = 1'b0; low = 0; lowresp_bad = 1'b0; budget = 0;
    dph = mk(1'b0, 2'd0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0);
    ready_prev = hreadyout[d];
    present(d, ws, idx, pres, pres_v);
    while ((pres_v || dph_v) && budget < 400) begin
      @(posedge clk); #1;
      budget++;
      if (ready_prev) begin
        dph_v = pres_v;
        dph   = pres;
        low   = 0;
        lowresp_bad = 1'b0;
        present(d, ws, idx, pres, pres_v);
      end
      if (dph_v) begin
        hwdata[d] = dph.wdata;
        if (!hreadyout[d]) begin
          low++;
          if (hresp[d] !== exp_q[0].err) lowresp_bad = 1'b1;
        end else begin
          e = exp_q.pop_front();
          check($sformatf("hresp[%0d] @%h", d, dph.addr), {31'b0, hresp[d]}, {31'b0, e.err});
          check($sformatf("low_cycles[%0d] @%h", d, dph.addr), 32'(low), 32'(e.low));
          if (low > 0)
            check($sformatf("low_hresp[%0d] @%h", d, dph.addr), {31'b0, lowresp_bad}, 32'h0);
          if (e.chk_rd)
            check($sformatf("hrdata[%0d] @%h", d, dph.addr), hrdata[d], e.rdata);
          dph_v = 1'b0;
        end
      end
      ready_prev = hreadyout[d];
    end
    if (budget >= 400) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout[%0d]: sequence stalled after %0d cycles", d, budget);
    end
    check($sformatf("scoreboard_empty[%0d]", d), 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  vec_t v0[$];
  vec_t v1[$];

  initial begin
    // Zero-wait instance: forwarding, byte lanes, errors, idle/busy/unselected.
    v0.push_back(wr(32'h00, 3'd2, 32'h11111111, 1'b0));
    v0.push_back(wr(32'h10, 3'd2, 32'hDEADBEEF, 1'b0));
    v0.push_back(rd(32'h10, 3'd2, 32'hDEADBEEF, 1'b0));
    v0.push_back(wr(32'h20, 3'd2, 32'h12345678, 1'b0));
    v0.push_back(wr(32'h21, 3'd0, 32'h0000AA00, 1'b0));
    v0.push_back(wr(32'h22, 3'd1, 32'hBBCC0000, 1'b0));
    v0.push_back(rd(32'h20, 3'd2, 32'hBBCCAA78, 1'b0));
    v0.push_back(wr(32'h04, 3'd2, 32'h0BADF00D, 1'b0));
    v0.push_back(wr(32'h100, 3'd2, 32'hFFFFFFFF, 1'b1));
    v0.push_back(wr(32'h05, 3'd1, 32'h00FFFF00, 1'b1));
    v0.push_back(rd(32'h08, 3'd3, 32'h0, 1'b1));
    v0.push_back(wr(32'h22, 3'd2, 32'hFFFFFFFF, 1'b1));
    v0.push_back(rd(32'h04, 3'd2, 32'h0BADF00D, 1'b0));
    v0.push_back(rd(32'h00, 3'd2, 32'h11111111, 1'b0));
    v0.push_back(wr(32'h40, 3'd2, 32'hCAFEF00D, 1'b0));
    v0.push_back(mk(1'b1, 2'd0, 1'b1, 32'h40, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0));
    v0.push_back(mk(1'b1, 2'd1, 1'b1, 32'h40, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0));
    v0.push_back(mk(1'b0, 2'd2, 1'b1, 32'h40, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0));
    v0.push_back(rd(32'h40, 3'd2, 32'hCAFEF00D, 1'b0));
    v0.push_back(wr(32'hFC, 3'd2, 32'h76543210, 1'b0));
    v0.push_back(rd(32'hFC, 3'd2, 32'h76543210, 1'b0));
    v0.push_back(rd(32'h21, 3'd0, 32'hBBCCAA78, 1'b0));

    // Three-wait instance: stalled reads/writes, byte lane, error without waits.
    v1.push_back(wr(32'h04, 3'd2, 32'h01020304, 1'b0));
    v1.push_back(rd(32'h04, 3'd2, 32'h01020304, 1'b0));
    v1.push_back(wr(32'h30, 3'd2, 32'hA5A5A5A5, 1'b0));
    v1.push_back(wr(32'h31, 3'd0, 32'h0000EE00, 1'b0));
    v1.push_back(rd(32'h30, 3'd2, 32'hA5A5EEA5, 1'b0));
    v1.push_back(wr(32'h100, 3'd2, 32'h0, 1'b1));
    v1.push_back(rd(32'h04, 3'd2, 32'h01020304, 1'b0));

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      drive_idle(d);
      hwdata[d] = 32'h0;
      hburst[d] = 3'd0;
      hprot[d]  = 4'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_hreadyout[%0d]", d), {31'b0, hreadyout[d]}, 32'h1);
      check($sformatf("reset_hresp[%0d]", d), {31'b0, hresp[d]}, 32'h0);
      check($sformatf("reset_hrdata[%0d]", d), hrdata[d], 32'h0);
    end
    #3;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;

    cur_q = v0;
    run_seq(0, 0);

    // HRDATA must hold the last read value through idle cycles.
    repeat (3) @(posedge clk);
    #1;
    check("hrdata_hold[0]", hrdata[0], 32'hBBCCAA78);
    check("idle_hreadyout[0]", {31'b0, hreadyout[0]}, 32'h1);

    cur_q = v1;
    run_seq(1, 3);

    // Reset during the wait phase of a write: the write must be dropped.
    drive_addr(1, wr(32'h30, 3'd2, 32'h5A5A5A5A, 1'b0));
    @(posedge clk); #1;
    check("wait_entered[1]", {31'b0, hreadyout[1]}, 32'h0);
    drive_idle(1);
    hwdata[1] = 32'h5A5A5A5A;
    @(posedge clk); #2;
    rst_n[1] = 1'b0;
    #1;
    check("async_rst_hreadyout[1]", {31'b0, hreadyout[1]}, 32'h1);
    check("async_rst_hresp[1]", {31'b0, hresp[1]}, 32'h0);
    check("async_rst_hrdata[1]", hrdata[1], 32'h0);
    @(posedge clk); #2;
    rst_n[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    cur_q.delete();
    cur_q.push_back(rd(32'h30, 3'd2, 32'hA5A5EEA5, 1'b0));
    run_seq(1, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb3lite_sram_ws.md
# ahb3lite_sram_ws

AHB3-Lite SRAM slave with parametrised data width, depth and wait-state count. It adds byte-lane writes, a two-cycle ERROR response for illegal transfers, and write-to-read forwarding. It replaces the fixed zero-wait single-port SRAM slave as the default memory target on the AHB3-Lite bus and uses the same port set, so the existing bus interface and test cases connect unchanged.

## Interface
- MEM_SIZE, 256: memory size in bytes; power of two, ≥ HDATA_SIZE/8.
- HADDR_SIZE, 32: address width.
- HDATA_SIZE, 32: data width; 32 or 64.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in every legal data phase; range 0..7.
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  HADDR_SIZE  byte address.
- HWDATA  in  HDATA_SIZE  write data, little-endian lanes.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, log2 of bytes.
- HBURST  in  3  burst type; accepted, no functional effect.
- HPROT  in  4  protection; accepted, no functional effect.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HREADY  in  1  bus-level ready (previous transfer complete).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  HDATA_SIZE  read data.

## Operation
- The slave accepts an address phase on a rising edge when HSEL & HREADY & HTRANS[1]. It registers addr, write, size and lane mask. IDLE, BUSY and unselected cycles produce zero-wait OKAY with no memory access.
- A transfer is illegal if any of these hold: HADDR ≥ MEM_SIZE; HSIZE > log2(HDATA_SIZE/8); HADDR not aligned to 2^HSIZE.
- FSM states:
  - S_IDLE: HREADYOUT=1, HRESP=0.
  - S_WAIT: counter loads WAIT_STATES-1 and decrements; HREADYOUT=0.
  - S_DONE: one cycle, HREADYOUT=1; read data presented, write committed.
  - S_ERR1: HRESP=1, HREADYOUT=0.
  - S_ERR2: HRESP=1, HREADYOUT=1.
- Transitions on an accepted transfer:
  - Legal, WAIT_STATES=0: go to S_DONE.
  - Legal, WAIT_STATES>0: go to S_WAIT, then S_DONE.
  - Illegal: S_ERR1, then S_ERR2. No wait states are added and memory is not touched.
- In S_DONE or S_ERR2 a new accepted address phase chains directly to its next state. Otherwise the FSM returns to S_IDLE.
- Lane mask = (2^(2^HSIZE) − 1) << HADDR[log2(HDATA_SIZE/8)-1:0]. A write updates only the masked bytes, using HWDATA sampled on the S_DONE edge.
- Read data = full word at HADDR with bits above the word index truncated; all lanes are driven. HRDATA holds its last value outside S_DONE reads.
- Forwarding: if a read's data phase reads a word committed by a write in the immediately preceding S_DONE cycle, the returned word is the memory word merged with the write's masked lanes. No stale data is permitted.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0. The FSM enters S_IDLE and the counter clears. Memory contents are unaffected.
- Legal transfer with address phase in cycle N: HREADYOUT=0 for cycles N+1..N+WAIT_STATES; HREADYOUT=1 in cycle N+1+WAIT_STATES. HRDATA is valid in that same cycle.
- Error with address phase in cycle N: HRESP=1 in cycles N+1 and N+2; HREADYOUT=0 in N+1 and 1 in N+2.
- While HREADYOUT=0, address-phase inputs are ignored, because HREADY is low.
- Back-to-back zero-wait pipelined transfers sustain one transfer per cycle.
- Reset asserted mid data phase: the pending write is dropped and outputs take reset values asynchronously.

## Test plan
- WAIT_STATES=0, HDATA_SIZE=32: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back. Read returns 0xDEADBEEF, forwarded, one cycle after its address phase.
- Over 0x12345678 at 0x20, write byte 0xAA at 0x21 and halfword 0xBBCC at 0x22, then read word 0x20. Read returns 0xBBCCAA78.
- WAIT_STATES=3: single read at 0x04. Three HREADYOUT-low cycles, then data in the 4th cycle. Write with a wait state lands after exactly 3 low cycles.
- HADDR=MEM_SIZE write, and halfword at odd address 0x05. Each gives HRESP=1 for 2 cycles, HREADYOUT pattern 0,1. A follow-up read shows memory unchanged.
- IDLE/BUSY with HSEL=1, and NONSEQ with HSEL=0. HREADYOUT stays 1, HRESP stays 0, no write occurs.
- Assert HRESETn low during S_WAIT of a write to 0x30. HREADYOUT=1 and HRESP=0 immediately; a later read of 0x30 returns the old value.
